// File: rtl/mux10_rr_arbiter.sv
// Round-robin owner scheduler for a shared N:1 mux: one-hot GNT, select SL and VALID, all registered.
// REQ->GNT latency 1 cycle; one dead cycle between owners; bursts capped at MAX_HOLD (0 = no cap).
module mux10_rr_arbiter #(
    parameter int N_REQ    = 10,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SL,
    output logic             VALID,
    output logic             OWNER_LAST
);

    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [N_REQ-1:0]  GNT_ONE  = N_REQ'(1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_REQ - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sl_q, sl_d;
    logic             valid_q, valid_d;
    logic             owner_last_q, owner_last_d;

    logic             hi_found;
    logic [SEL_W-1:0] hi_pick, lo_pick, pick;
    logic             owner_req, release_now;
    logic [HOLD_W-1:0] hold_inc;

    // Rotating priority: lowest requester at or above PTR, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                lo_pick = SEL_W'(i);
                if (SEL_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_pick  = SEL_W'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    assign owner_req   = |(REQ & gnt_q);
    assign release_now = !owner_req || ((MAX_HOLD != 0) && (hold_q == HOLD_MAX));
    assign hold_inc    = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_ONE;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        gnt_d        = gnt_q;
        sl_d         = sl_q;
        owner_last_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    state_d      = S_BUSY;
                    gnt_d        = GNT_ONE << pick;
                    sl_d         = pick;
                    hold_d       = HOLD_ONE;
                    owner_last_d = (MAX_HOLD == 1);
                end
            end
            default: begin
                if (release_now) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                    ptr_d   = (sl_q == SEL_LAST) ? '0 : sl_q + SEL_W'(1);
                end else begin
                    hold_d       = hold_inc;
                    owner_last_d = (MAX_HOLD != 0) && (hold_inc == HOLD_MAX);
                end
            end
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            hold_q       <= '0;
            gnt_q        <= '0;
            sl_q         <= '0;
            valid_q      <= 1'b0;
            owner_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            gnt_q        <= gnt_d;
            sl_q         <= sl_d;
            valid_q      <= valid_d;
            owner_last_q <= owner_last_d;
        end
    end

    assign GNT        = gnt_q;
    assign SL         = sl_q;
    assign VALID      = valid_q;
    assign OWNER_LAST = owner_last_q;

endmodule
